prirv32_mem_arbiter: RTL
========================

// Module: prirv32_mem_arbiter
// PURPOSE
//  Shares one single-outstanding memory port between the data requester (EXU load/store) and the
//  instruction requester (IFU fetch). Arbitrates, latches the winning request, drives the memory
//  port until mem_ready_i or timeout, returns read data/status to the owner. Sits between the core
//  top-level and the memory/bus interface.
// PARAMETERS
//  ADDR_W      32   address width
//  DATA_W      32   data width (multiple of 8); strobe width DATA_W/8
//  TMO_CYCLES  64   BUSY cycles without mem_ready_i before error termination; 0 = never time out
// PORTS
//  clk_i        in   1          clock, rising edge
//  rst_i        in   1          reset, asynchronous, active-high
//  d_req_i      in   1          data request
//  d_we_i       in   1          data write enable (1 = store)
//  d_addr_i     in   ADDR_W     data address
//  d_wdata_i    in   DATA_W     store data
//  d_wstrb_i    in   DATA_W/8   store byte strobes
//  d_gnt_o      out  1          data request accepted (1-cycle pulse)
//  d_rvalid_o   out  1          data response valid (1-cycle pulse)
//  d_rdata_o    out  DATA_W     load data, valid with d_rvalid_o
//  d_err_o      out  1          data response is timeout error, valid with d_rvalid_o
//  i_req_i      in   1          fetch request (read only)
//  i_addr_i     in   ADDR_W     fetch address
//  i_gnt_o / i_rvalid_o / i_rdata_o / i_err_o   out  1/1/DATA_W/1   as data side, for fetch
//  mem_req_o    out  1          memory access active
//  mem_we_o     out  1          memory write
//  mem_addr_o   out  ADDR_W     memory address
//  mem_wdata_o  out  DATA_W     memory write data
//  mem_wstrb_o  out  DATA_W/8   memory byte strobes
//  mem_ready_i  in   1          memory completes current access this cycle
//  mem_rdata_i  in   DATA_W     read data, sampled with mem_ready_i
//  busy_o       out  1          arbiter in BUSY
// BEHAVIOUR
//  - Reset: state IDLE, every output 0, owner/last-owner = fetch, timeout counter 0. Reset mid-access
//    aborts silently: no rvalid to the owner, mem_req_o drops asynchronously.
//  - FSM IDLE -> BUSY: any req sampled high in IDLE; winner's addr/we/wdata/wstrb registered onto
//    mem_*; winner's gnt_o pulses the next cycle (first BUSY cycle). Fetch always mem_we_o=0, wstrb=0.
//  - Requester holds req and payload until gnt_o; req seen during BUSY is ignored (not queued).
//  - BUSY: mem_req_o=1, mem_* stable. On mem_ready_i=1: mem_rdata_i registered to owner rdata_o,
//    owner rvalid_o pulses next cycle with err_o=0 (rdata_o also updated for stores), -> IDLE.
//  - Latency: req at cycle N -> gnt + mem_req_o at N+1 -> ready at N+1 earliest -> rvalid at N+2.
//    Back-to-back: next arbitration samples req in the IDLE cycle coinciding with rvalid.
//  - Timeout: counter increments each BUSY cycle without ready; when it equals TMO_CYCLES -> rvalid
//    with err_o=1, rdata_o=0, -> IDLE. mem_ready_i and mem_rdata_i in IDLE are ignored.
//  - rdata_o holds last value between responses; gnt/rvalid/err are single-cycle pulses.
//  - Arbitration (both req in IDLE): data wins (fixed priority); see CONFIGURATION.
//  - Counter width = clog2(TMO_CYCLES+1); no wrap possible; cleared on entering BUSY.
// CONFIGURATION
//  PRIRV32_ARB_RR_EN defined: round-robin; on simultaneous req the requester that is not last owner
//    wins; last-owner updated at each grant; reset last-owner = fetch, so data wins first tie.
//  Undefined: fixed priority, data always beats fetch (fetch may starve under continuous data req).
// TESTING
//  1 Fetch only: i_req_i=1, i_addr_i=0x100, mem_ready_i at N+1 with rdata 0x00000013
//    -> i_gnt_o @N+1, mem_addr_o=0x100 mem_we_o=0, i_rvalid_o @N+2, i_rdata_o=0x13, i_err_o=0.
//  2 Store: d_we_i=1, addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF, ready after 3 wait cycles
//    -> mem_* stable 4 cycles, d_rvalid_o 1 pulse, d_err_o=0, no i_* activity.
//  3 Tie, macro undefined: both req continuously for 3 accesses -> 3 data grants, 0 fetch grants.
//    Macro defined: grant order data, fetch, data.
//  4 Timeout, TMO_CYCLES=4: read, mem_ready_i held 0 -> rvalid with err_o=1, rdata_o=0 after 4
//    BUSY cycles; mem_ready_i pulsed next cycle ignored (no extra rvalid).
//  5 rst_i asserted 2 cycles into BUSY -> mem_req_o, busy_o, all outputs 0 immediately; no rvalid.

Source files
------------

// File: rtl/prirv32_mem_arbiter.sv
// Two-requester arbiter (data + fetch) for a single-outstanding memory port with timeout.
// Define PRIRV32_ARB_RR_EN for round-robin arbitration; the default is fixed priority (data first).
module prirv32_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TMO_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // data requester
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wstrb_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_err_o,
    // fetch requester
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_gnt_o,
    output logic                i_rvalid_o,
    output logic [DATA_W-1:0]   i_rdata_o,
    output logic                i_err_o,
    // memory port
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_ready_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TMO_CYCLES > 0) ? $clog2(TMO_CYCLES + 1) : 1;
    localparam logic [CNT_W:0] TMO_LIM = (CNT_W + 1)'(TMO_CYCLES);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t            state;
    state_t            next_state;
    logic              owner_fetch;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W:0]    cnt_inc;
    logic              tmo_hit;
    logic              pick_data;
    logic              grant_d;
    logic              grant_i;
    logic              done;
    logic              tmo_fire;
    logic [DATA_W-1:0] rsp_data;

`ifdef PRIRV32_ARB_RR_EN
    logic last_fetch;

    // On a tie the side that did not win last time goes first.
    assign pick_data = d_req_i && (!i_req_i || last_fetch);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_fetch <= 1'b1;
        end else if (grant_d) begin
            last_fetch <= 1'b0;
        end else if (grant_i) begin
            last_fetch <= 1'b1;
        end
    end
`else
    assign pick_data = d_req_i;
`endif

    assign cnt_inc   = {1'b0, tmo_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign tmo_hit   = (TMO_CYCLES != 0) && (cnt_inc == TMO_LIM);
    assign mem_req_o = (state == StBusy);
    assign busy_o    = (state == StBusy);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= StIdle;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        done       = 1'b0;
        tmo_fire   = 1'b0;
        cnt_next   = tmo_cnt;
        rsp_data   = mem_rdata_i;
        unique case (state)
            StIdle: begin
                if (d_req_i || i_req_i) begin
                    next_state = StBusy;
                    grant_d    = pick_data;
                    grant_i    = !pick_data;
                    cnt_next   = '0;
                end
            end
            StBusy: begin
                if (mem_ready_i) begin
                    done       = 1'b1;
                    next_state = StIdle;
                end else if (tmo_hit) begin
                    tmo_fire   = 1'b1;
                    rsp_data   = '0;
                    next_state = StIdle;
                end else begin
                    cnt_next = (TMO_CYCLES != 0) ? cnt_inc[CNT_W-1:0] : '0;
                end
            end
            default: next_state = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_fetch <= 1'b1;
            tmo_cnt     <= '0;
            d_gnt_o     <= 1'b0;
            i_gnt_o     <= 1'b0;
            d_rvalid_o  <= 1'b0;
            i_rvalid_o  <= 1'b0;
            d_err_o     <= 1'b0;
            i_err_o     <= 1'b0;
            d_rdata_o   <= '0;
            i_rdata_o   <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else begin
            tmo_cnt    <= cnt_next;
            d_gnt_o    <= grant_d;
            i_gnt_o    <= grant_i;
            d_rvalid_o <= (done || tmo_fire) && !owner_fetch;
            i_rvalid_o <= (done || tmo_fire) && owner_fetch;
            d_err_o    <= tmo_fire && !owner_fetch;
            i_err_o    <= tmo_fire && owner_fetch;
            if (grant_d) begin
                owner_fetch <= 1'b0;
                mem_we_o    <= d_we_i;
                mem_addr_o  <= d_addr_i;
                mem_wdata_o <= d_wdata_i;
                mem_wstrb_o <= d_wstrb_i;
            end else if (grant_i) begin
                owner_fetch <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= i_addr_i;
                mem_wdata_o <= '0;
                mem_wstrb_o <= {STRB_W{1'b0}};
            end
            if (done || tmo_fire) begin
                if (owner_fetch) begin
                    i_rdata_o <= rsp_data;
                end else begin
                    d_rdata_o <= rsp_data;
                end
            end
        end
    end

endmodule
